// File: rtl/ram_pipe.sv
// ram_pipe: single-port word RAM with byte-lane writes,
// a LAT-deep elastic read pipeline and a sticky write lock.
module ram_pipe #(
  parameter int DP  = 4096,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     addr_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [DW-1:0]   data_i,
  input  logic            lock_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   data_o,
  output logic            err_o,
  output logic            locked_o
);

  localparam int IW = $clog2(DP);
  localparam int NB = DW / 8;

  typedef struct packed {
    logic          v;
    logic          e;
    logic [DW-1:0] d;
  } stg_t;

  logic [DW-1:0]  mem [DP];
  stg_t           stg_q [LAT];
  stg_t           head;
  logic [LAT-1:0] free;
  logic [31:0]    widx;
  logic [IW-1:0]  ridx;
  logic           in_rng;
  logic           wr_en;
  logic           locked_q;
  logic           unused_addr;

  assign unused_addr = ^{addr_i[31:28], addr_i[1:0]};

  // word index from the byte address, sized by word width
  always_comb begin
    if (DW == 64) widx = {7'd0, addr_i[27:3]};
    else          widx = {6'd0, addr_i[27:2]};
  end

  assign in_rng = widx < 32'(DP);
  assign ridx   = widx[IW-1:0];

  // a stage is free if empty or its occupant leaves this cycle
  always_comb begin
    free[LAT-1] = !stg_q[LAT-1].v || rsp_ready_i;
    for (int i = LAT - 2; i >= 0; i--) begin
      free[i] = !stg_q[i].v || free[i+1];
    end
  end

  assign req_ready_o = free[0] & ~rst;

  assign wr_en = req_valid_i & req_ready_o & we_i
               & in_rng & ~locked_q;

  // response entry built from the incoming request
  always_comb begin
    head   = '0;
    head.v = req_valid_i;
    if (!in_rng) begin
      head.e = 1'b1;
    end else if (we_i) begin
      head.e = locked_q;
    end else begin
      head.d = mem[ridx];
    end
  end

  // elastic pipeline: each stage pulls from the one behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        stg_q[i] <= '0;
      end
    end else begin
      if (free[0]) begin
        stg_q[0] <= head;
      end
      for (int i = 1; i < LAT; i++) begin
        if (free[i]) begin
          stg_q[i] <= stg_q[i-1];
        end
      end
    end
  end

  // byte-lane array write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_i[b]) begin
          mem[ridx][b*8 +: 8] <= data_i[b*8 +: 8];
        end
      end
    end
  end

  // sticky write protect, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else if (lock_i) begin
      locked_q <= 1'b1;
    end
  end

  assign rsp_valid_o = stg_q[LAT-1].v;
  assign data_o      = stg_q[LAT-1].v ? stg_q[LAT-1].d : '0;
  assign err_o       = stg_q[LAT-1].v & stg_q[LAT-1].e;
  assign locked_o    = locked_q;

endmodule

// File: tb/tb_ram_pipe.sv
// tb_ram_pipe: directed + random checks of ram_pipe against
// a transaction-level memory model (LAT=3 and LAT=2 instances).
module tb_ram_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string tag, logic [63:0] obs,
                              logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // instance A: LAT=3
  logic        a_rst, a_req_valid, a_req_ready, a_we, a_lock;
  logic [31:0] a_addr, a_data, a_data_o;
  logic [3:0]  a_sel;
  logic        a_rsp_valid, a_rsp_ready, a_err, a_locked;

  ram_pipe #(.DP(4096), .DW(32), .LAT(3)) u_a (
    .clk(clk), .rst(a_rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
    .addr_i(a_addr), .we_i(a_we), .sel_i(a_sel),
    .data_i(a_data), .lock_i(a_lock),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .data_o(a_data_o), .err_o(a_err), .locked_o(a_locked)
  );

  // instance B: LAT=2
  logic        b_rst, b_req_valid, b_req_ready, b_we, b_lock;
  logic [31:0] b_addr, b_data, b_data_o;
  logic [3:0]  b_sel;
  logic        b_rsp_valid, b_rsp_ready, b_err, b_locked;

  ram_pipe #(.DP(4096), .DW(32), .LAT(2)) u_b (
    .clk(clk), .rst(b_rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .addr_i(b_addr), .we_i(b_we), .sel_i(b_sel),
    .data_i(b_data), .lock_i(b_lock),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .data_o(b_data_o), .err_o(b_err), .locked_o(b_locked)
  );

  // reference model for A
  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } rsp_t;

  rsp_t        q[$];
  rsp_t        r;
  logic [31:0] mdl [4096];
  bit          lk = 0;
  bit          held = 0;
  bit          mon_a = 0;
  bit          rnd_rdy = 0;
  int          cyc = 0;
  int          last_stall = 0;
  int          idx;

  always @(negedge clk) begin
    cyc++;
    if (mon_a) chk("a_locked", 64'(a_locked), 64'(lk));
    if (a_rst) begin
      if (mon_a) chk("a_ready_in_rst", 64'(a_req_ready), 64'(0));
      q.delete();
      lk = 0;
      held = 0;
      last_stall = cyc;
    end else if (mon_a) begin
      if (a_rsp_valid) begin
        if (q.size() == 0) begin
          chk("a_spurious_rsp", 64'(a_rsp_valid), 64'(0));
        end else begin
          if (!held) begin
            if (q[0].c >= last_stall)
              chk("a_latency", 64'(cyc - q[0].c), 64'(3));
            else
              chk("a_latency_min", 64'((cyc - q[0].c) >= 3), 64'(1));
          end
          chk("a_data", 64'(a_data_o), 64'(q[0].d));
          chk("a_err", 64'(a_err), 64'(q[0].e));
          if (a_rsp_ready) begin
            void'(q.pop_front());
            held = 0;
          end else begin
            held = 1;
          end
        end
      end else if (held) begin
        chk("a_hold_valid", 64'(a_rsp_valid), 64'(1));
        held = 0;
      end
      if (!a_rsp_ready) last_stall = cyc;
      if (a_req_valid && a_req_ready) begin
        idx = int'(a_addr[27:2]);
        r.c = cyc;
        r.d = 32'd0;
        r.e = 1'b0;
        if (idx >= 4096) begin
          r.e = 1'b1;
        end else if (!a_we) begin
          r.d = mdl[idx];
        end else if (lk) begin
          r.e = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (a_sel[b]) mdl[idx][8*b +: 8] = a_data[8*b +: 8];
        end
        q.push_back(r);
      end
      if (a_lock) lk = 1;
    end
  end

  task automatic a_op(input bit we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] d,
                      input bit lock);
    int n;
    n = 0;
    a_req_valid = 1'b1;
    a_we = we;
    a_addr = addr;
    a_sel = sel;
    a_data = d;
    a_lock = lock;
    forever begin
      a_rsp_ready = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
      @(negedge clk);
      if (a_req_ready) break;
      n++;
      if (n > 50) begin
        chk("a_accept_timeout", 64'(a_req_ready), 64'(1));
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    a_lock = 1'b0;
  endtask

  task automatic a_idle(input int n);
    for (int i = 0; i < n; i++) begin
      a_req_valid = 1'b0;
      a_rsp_ready = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] bv [8];
  logic [31:0] ra;
  int          acc, got;

  initial begin
    a_rst = 1; a_req_valid = 0; a_we = 0; a_lock = 0;
    a_addr = 0; a_data = 0; a_sel = 0; a_rsp_ready = 1;
    b_rst = 1; b_req_valid = 0; b_we = 0; b_lock = 0;
    b_addr = 0; b_data = 0; b_sel = 0; b_rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 0;
    b_rst = 0;
    mon_a = 1;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(a_rsp_valid), 64'(0));
    chk("rst_data", 64'(a_data_o), 64'(0));
    chk("rst_err", 64'(a_err), 64'(0));
    chk("rst_ready", 64'(a_req_ready), 64'(1));
    chk("rst_locked", 64'(a_locked), 64'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++)
      a_op(1, 32'(i * 4), 4'hF, $urandom, 0);

    a_op(1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    a_op(0, 32'h10, 4'h0, 32'h0, 0);
    a_idle(4);

    a_op(1, 32'h20, 4'hF, 32'hFFFFFFFF, 0);
    a_op(1, 32'h20, 4'h2, 32'h00000000, 0);
    a_op(0, 32'h20, 4'h0, 32'h0, 0);
    a_op(1, 32'h20, 4'h0, 32'h12345678, 0);
    a_op(0, 32'h20, 4'h0, 32'h0, 0);

    a_op(0, 32'h4000, 4'h0, 32'h0, 0);
    a_op(1, 32'h4000, 4'hF, 32'hA5A5A5A5, 0);
    a_op(0, 32'h0, 4'h0, 32'h0, 0);
    a_idle(4);

    // B: 8 back-to-back reads with a response stall
    for (int i = 0; i < 8; i++) bv[i] = $urandom;
    b_rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      b_req_valid = 1; b_we = 1; b_sel = 4'hF;
      b_addr = 32'(i * 4); b_data = bv[i];
      @(negedge clk);
      chk("b_wr_ready", 64'(b_req_ready), 64'(1));
      @(posedge clk);
      #1;
    end
    b_req_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    acc = 0;
    got = 0;
    for (int t = 0; t < 16; t++) begin
      b_req_valid = (acc < 8);
      b_we = 0;
      b_addr = 32'(acc * 4);
      b_rsp_ready = !(t >= 3 && t <= 6);
      @(negedge clk);
      if (t < 12)
        chk("b_req_ready", 64'(b_req_ready),
            64'(!(t >= 3 && t <= 6)));
      chk("b_rsp_valid", 64'(b_rsp_valid), 64'(t >= 2 && t <= 13));
      if (b_rsp_valid) begin
        chk("b_data", 64'(b_data_o), 64'(got < 8 ? bv[got] : 0));
        chk("b_err", 64'(b_err), 64'(0));
        if (b_rsp_ready) got++;
      end
      if (b_req_valid && b_req_ready) acc++;
      @(posedge clk);
      #1;
    end
    b_req_valid = 0;
    chk("b_rsp_count", 64'(got), 64'(8));

    rnd_rdy = 1;
    for (int k = 0; k < 300; k++) begin
      ra = $urandom;
      if ($urandom_range(9) != 0)
        ra[27:2] = 26'($urandom_range(15));
      else
        ra[27:2] = 26'($urandom) | 26'h1000;
      a_op(1'($urandom), ra, 4'($urandom), $urandom, 0);
      if ($urandom_range(4) == 0) a_idle(1);
    end
    rnd_rdy = 0;
    a_idle(6);

    a_op(1, 32'h0, 4'hF, 32'h11, 1);
    a_op(1, 32'h0, 4'hF, 32'h22, 0);
    a_op(0, 32'h0, 4'h0, 32'h0, 0);
    a_idle(4);
    chk("locked_set", 64'(a_locked), 64'(1));

    rnd_rdy = 1;
    for (int k = 0; k < 60; k++) begin
      ra = 32'($urandom_range(15) * 4);
      a_op(1'($urandom), ra, 4'($urandom), $urandom, 0);
    end
    rnd_rdy = 0;
    a_idle(6);

    a_op(0, 32'h0, 4'h0, 32'h0, 0);
    a_op(0, 32'h4, 4'h0, 32'h0, 0);
    a_rst = 1;
    a_req_valid = 1; a_we = 1; a_addr = 32'h4;
    a_sel = 4'hF; a_data = 32'h0BADF00D;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 0;
    a_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(a_rsp_valid), 64'(0));
      chk("post_rst_data", 64'(a_data_o), 64'(0));
      chk("post_rst_err", 64'(a_err), 64'(0));
      chk("post_rst_ready", 64'(a_req_ready), 64'(1));
      @(posedge clk);
      #1;
    end
    chk("post_rst_locked", 64'(a_locked), 64'(0));
    a_op(0, 32'h0, 4'h0, 32'h0, 0);
    a_op(0, 32'h4, 4'h0, 32'h0, 0);
    a_op(1, 32'h8, 4'hF, 32'hCAFEF00D, 0);
    a_op(0, 32'h8, 4'h0, 32'h0, 0);
    a_idle(8);
    chk("a_queue_drained", 64'(q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
